// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: synchronizes rx_in, finds the start bit, samples each bit
// at mid-period LSB first and reports a good byte or a framing error.
module uart_rx_fsm #(
  parameter int CLK_PER_BIT       = 5208,
  parameter int DATA_BITS         = 8,
  parameter int CLK_COUNTER_WIDTH = $clog2(CLK_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int IDX_WIDTH = $clog2(DATA_BITS + 1);
  localparam logic [CLK_COUNTER_WIDTH-1:0] HALF_M1 = CLK_COUNTER_WIDTH'(CLK_PER_BIT / 2 - 1);
  localparam logic [CLK_COUNTER_WIDTH-1:0] BIT_M1  = CLK_COUNTER_WIDTH'(CLK_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0]         IDX_LAST = IDX_WIDTH'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                       state;
  logic                         rx_meta;
  logic                         rx_s;
  logic                         rx_prev;
  logic [1:0]                   settle;
  logic [CLK_COUNTER_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0]         idx;
  logic [DATA_BITS-1:0]         shreg;

  // The synchronizer holds its reset value for two cycles, so rx_prev ignores it
  // until real line samples arrive; a line held low through reset cannot fake a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b0;
      settle  <= 2'd0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      if (settle != 2'd2) settle <= settle + 2'd1;
      rx_prev <= (settle == 2'd2) ? rx_s : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          cnt  <= '0;
          idx  <= '0;
          if (rx_prev && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CLK_COUNTER_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= STOP;
            end else begin
              idx <= idx + IDX_WIDTH'(1);
            end
          end else begin
            cnt <= cnt + CLK_COUNTER_WIDTH'(1);
          end
        end
        STOP: begin
          // Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught.
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CLK_COUNTER_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: each driven frame queues its expected pulse,
// byte and arrival cycle; the monitor pops and checks on every output pulse.
module tb_uart_rx_fsm;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  typedef struct {
    int         fall;
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fails = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] model_data = 8'h00;
  exp_t       sb[$];

  uart_rx_fsm #(.CLK_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idleLine(input int n);
    @(negedge clk) rx_in = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  // Drives one full frame (start, 8 data bits LSB first, stop) and queues its outcome.
  task automatic applyStimulus(input logic [7:0] b, input logic stop);
    exp_t e;
    @(negedge clk) rx_in = 1'b0;
    e.fall = cyc;
    e.kind = stop ? 2'b10 : 2'b01;
    if (stop) model_data = b;
    e.data = model_data;
    sb.push_back(e);
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx_in = b[i];
      if (i == 4) checkOutput("busy_mid_frame", busy, 1);
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx_in = stop;
    repeat (CPB - 1) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (data_valid || framing_err) begin
      checkOutput("pulse_width", prev_pulse, 0);
      if (sb.size() == 0) begin
        checkOutput("spurious_pulse", {data_valid, framing_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pulse_kind", {data_valid, framing_err}, e.kind);
        checkOutput("data_out", data_out, e.data);
        checkOutput("latency", cyc - e.fall, LAT);
      end
      if (data_valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
    end
    prev_pulse = data_valid || framing_err;
  end

  initial begin
    int fall;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_data_valid", data_valid, 0);
    checkOutput("reset_framing_err", framing_err, 0);
    checkOutput("reset_busy", busy, 0);
    rst = 1'b0;
    idleLine(2 * CPB);

    // Single good byte
    applyStimulus(8'hA5, 1'b1);
    checkOutput("busy_after_stop", busy, 0);
    idleLine(2 * CPB);

    // Back-to-back frames without idle gap
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idleLine(CPB);
    checkOutput("b2b_gap", last_valid_cyc - prev_valid_cyc, 10 * CPB);
    idleLine(CPB);

    // Bad stop bit: data_out must keep 0xFF
    applyStimulus(8'h3C, 1'b0);
    idleLine(3 * CPB);
    checkOutput("data_held_after_ferr", data_out, 8'hFF);

    // Short glitch on an idle line
    @(negedge clk) rx_in = 1'b0;
    fall = cyc;
    repeat (3) @(negedge clk);
    @(negedge clk) rx_in = 1'b1;
    while (cyc < fall + 6) @(negedge clk);
    checkOutput("busy_during_glitch", busy, 1);
    while (cyc < fall + 14) @(negedge clk);
    checkOutput("busy_after_glitch", busy, 0);
    idleLine(2 * CPB);
    applyStimulus(8'h5A, 1'b1);
    idleLine(2 * CPB);

    // Line held low for 30 bit times: one framing error only
    begin
      exp_t e;
      @(negedge clk) rx_in = 1'b0;
      e.fall = cyc;
      e.kind = 2'b01;
      e.data = model_data;
      sb.push_back(e);
      repeat (30 * CPB - 1) @(negedge clk);
    end
    idleLine(2 * CPB);
    applyStimulus(8'h81, 1'b1);
    idleLine(2 * CPB);

    // Reset during data bit 4 of 0xC3; the rest of the frame must be ignored
    begin
      logic [7:0] b;
      b = 8'hC3;
      @(negedge clk) rx_in = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk) rx_in = b[i];
        repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx_in = b[4];
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_data_out", data_out, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_pulses", {data_valid, framing_err}, 0);
      @(negedge clk) rst = 1'b0;
      model_data = 8'h00;
      repeat (CPB - 10) @(negedge clk);
      for (int i = 5; i < 8; i++) begin
        @(negedge clk) rx_in = b[i];
        repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx_in = 1'b1;
      repeat (CPB - 1) @(negedge clk);
    end
    idleLine(2 * CPB);
    checkOutput("data_after_drop", data_out, 0);
    applyStimulus(8'h7E, 1'b1);
    idleLine(2 * CPB);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
